// File: rtl/fmc_master.sv
// ---------------------------------------------------------------------------
// fmc_master
//
// Initiator for an FMC/FSMC-style multiplexed 16-bit address/data bus.
// It accepts one request at a time on a valid/ready interface and plays it
// out as ADDR -> AHLD -> DATA -> TURN strobe phases. It then returns a
// one-cycle completion pulse, plus read data when the request was a read.
//
// Optional feature: define FMC_NWAIT_EN to add the fmc_nwait input.
// While that input is low it stretches the DATA phase. A stall that lasts
// WAIT_TIMEOUT cycles ends DATA anyway and raises rsp_err.
//
// Ports:
//   sys_clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_wr/req_addr/req_wdata request contents, latched on accept
//   rsp_valid                 one-cycle completion pulse (first TURN cycle)
//   rsp_rdata                 read data, held until the next read completes
//   rsp_err                   stall timeout flag, qualified by rsp_valid
//   busy                      transaction in progress
//   fmc_ad_o/oe/i             split multiplexed address/data pad
//   fmc_ncs/nadv/nwe/noe      active-low bus strobes (all registered)
//   fmc_nwait                 active-low wait (FMC_NWAIT_EN builds only)
// ---------------------------------------------------------------------------
module fmc_master #(
    parameter int ADDSET       = 2,
    parameter int ADDHLD       = 1,
    parameter int DATAST       = 4,
    parameter int BUSTURN      = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] fmc_ad_o,
    output logic        fmc_ad_oe,
    input  logic [15:0] fmc_ad_i,
`ifdef FMC_NWAIT_EN
    input  logic        fmc_nwait,
`endif
    output logic        fmc_ncs,
    output logic        fmc_nadv,
    output logic        fmc_nwe,
    output logic        fmc_noe
);

    generate
        if (ADDSET < 1 || ADDSET > 255) begin : g_bad_addset
            $error("fmc_master: ADDSET must be in 1..255");
        end
        if (ADDHLD < 1 || ADDHLD > 255) begin : g_bad_addhld
            $error("fmc_master: ADDHLD must be in 1..255");
        end
        if (DATAST < 1 || DATAST > 255) begin : g_bad_datast
            $error("fmc_master: DATAST must be in 1..255");
        end
        if (BUSTURN < 1 || BUSTURN > 255) begin : g_bad_busturn
            $error("fmc_master: BUSTURN must be in 1..255");
        end
        if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
            $error("fmc_master: WAIT_TIMEOUT must be in 1..255");
        end
    endgenerate

    // The phase counter is loaded with (length - 1), so a phase ends when it reads 0.
    localparam logic [7:0] ADDSET_LD  = 8'(ADDSET - 1);
    localparam logic [7:0] ADDHLD_LD  = 8'(ADDHLD - 1);
    localparam logic [7:0] DATAST_LD  = 8'(DATAST - 1);
    localparam logic [7:0] BUSTURN_LD = 8'(BUSTURN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AHLD,
        S_DATA,
        S_TURN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        ncs_q, ncs_d;
    logic        nadv_q, nadv_d;
    logic        nwe_q, nwe_d;
    logic        noe_q, noe_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_o_q, ad_o_d;
    logic        data_exit;

`ifdef FMC_NWAIT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

    logic        nwait_meta_q, nwait_meta_d;
    logic        nwait_s_q, nwait_s_d;
    logic [7:0]  stall_q, stall_d;
    logic        rsp_err_q, rsp_err_d;
    logic        data_timeout;
`endif

    // State register and all registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ncs_q       <= 1'b1;
            nadv_q      <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_o_q      <= 16'd0;
`ifdef FMC_NWAIT_EN
            nwait_meta_q <= 1'b1;
            nwait_s_q    <= 1'b1;
            stall_q      <= 8'd0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            ncs_q       <= ncs_d;
            nadv_q      <= nadv_d;
            nwe_q       <= nwe_d;
            noe_q       <= noe_d;
            ad_oe_q     <= ad_oe_d;
            ad_o_q      <= ad_o_d;
`ifdef FMC_NWAIT_EN
            nwait_meta_q <= nwait_meta_d;
            nwait_s_q    <= nwait_s_d;
            stall_q      <= stall_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Next-state logic. The pin values are derived from the *next* state and
    // then registered, so each pin changes on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        data_exit   = 1'b0;
`ifdef FMC_NWAIT_EN
        nwait_meta_d = fmc_nwait;
        nwait_s_d    = nwait_meta_q;
        stall_d      = stall_q;
        rsp_err_d    = rsp_err_q;
        data_timeout = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ADDR;
                    cnt_d   = ADDSET_LD;
`ifdef FMC_NWAIT_EN
                    rsp_err_d = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_AHLD;
                    cnt_d   = ADDHLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_AHLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DATA;
                    cnt_d   = DATAST_LD;
`ifdef FMC_NWAIT_EN
                    stall_d = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
`ifdef FMC_NWAIT_EN
                    // Once the programmed length has elapsed, keep stalling while
                    // the target holds NWAIT low, up to the timeout limit.
                    if (nwait_s_q) begin
                        data_exit = 1'b1;
                    end else if (stall_q == WAIT_LIMIT) begin
                        data_exit    = 1'b1;
                        data_timeout = 1'b1;
                    end else begin
                        stall_d = stall_q + 8'd1;
                    end
`else
                    data_exit = 1'b1;
`endif
                end
            end
            S_TURN: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving DATA: complete the response and sample read data from the bus.
        if (data_exit) begin
            state_d     = S_TURN;
            cnt_d       = BUSTURN_LD;
            rsp_valid_d = 1'b1;
            if (!wr_q) begin
                rsp_rdata_d = fmc_ad_i;
            end
`ifdef FMC_NWAIT_EN
            rsp_err_d = data_timeout;
`endif
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        ncs_d       = !(state_d == S_ADDR || state_d == S_AHLD || state_d == S_DATA);
        nadv_d      = !(state_d == S_ADDR);
        nwe_d       = !(state_d == S_DATA && wr_d);
        noe_d       = !(state_d == S_DATA && !wr_d);
        ad_oe_d     = (state_d == S_ADDR) || (state_d == S_AHLD) || (state_d == S_DATA && wr_d);
        if (state_d == S_ADDR || state_d == S_AHLD) begin
            ad_o_d = addr_d;
        end else if (state_d == S_DATA && wr_d) begin
            ad_o_d = wdata_d;
        end else begin
            ad_o_d = 16'd0;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign fmc_ncs   = ncs_q;
    assign fmc_nadv  = nadv_q;
    assign fmc_nwe   = nwe_q;
    assign fmc_noe   = noe_q;
    assign fmc_ad_oe = ad_oe_q;
    assign fmc_ad_o  = ad_o_q;
`ifdef FMC_NWAIT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fmc_master.sv
// Bench for fmc_master: a default-parameter instance and a minimum-timing
// instance (all phases 1 cycle) share the request and bus inputs. Expected
// pin values come from a cycle-offset model of the phase layout.
module tb_fmc_master;

   // Phase lengths per instance: index 0 = defaults, index 1 = all ones.
   localparam int PA[2] = '{2, 1};
   localparam int PH[2] = '{1, 1};
   localparam int PD[2] = '{4, 1};
   localparam int PT[2] = '{1, 1};

   logic        sysClk = 1'b0;
   logic        rstN = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqWr = 1'b0;
   logic [15:0] reqAddr = 16'd0;
   logic [15:0] reqWdata = 16'd0;
   logic [15:0] fmcAdI = 16'd0;

   logic        reqReady [2];
   logic        rspValid [2];
   logic [15:0] rspRdata [2];
   logic        rspErr [2];
   logic        busyO [2];
   logic [15:0] adO [2];
   logic        adOe [2];
   logic        nCs [2];
   logic        nAdv [2];
   logic        nWe [2];
   logic        nOe [2];

   int compared = 0;
   int mismatched = 0;
   logic [15:0] lastRd [2];

   always #5 sysClk = ~sysClk;

   fmc_master uDef (
      .sys_clk(sysClk), .rst_n(rstN),
      .req_valid(reqValid), .req_ready(reqReady[0]), .req_wr(reqWr),
      .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]),
      .busy(busyO[0]), .fmc_ad_o(adO[0]), .fmc_ad_oe(adOe[0]), .fmc_ad_i(fmcAdI),
      .fmc_ncs(nCs[0]), .fmc_nadv(nAdv[0]), .fmc_nwe(nWe[0]), .fmc_noe(nOe[0])
   );

   fmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1)) uMin (
      .sys_clk(sysClk), .rst_n(rstN),
      .req_valid(reqValid), .req_ready(reqReady[1]), .req_wr(reqWr),
      .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]),
      .busy(busyO[1]), .fmc_ad_o(adO[1]), .fmc_ad_oe(adOe[1]), .fmc_ad_i(fmcAdI),
      .fmc_ncs(nCs[1]), .fmc_nadv(nAdv[1]), .fmc_nwe(nWe[1]), .fmc_noe(nOe[1])
   );

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Observed strobe vector {ncs,nadv,nwe,noe,oe,rsp_valid,busy,req_ready}.
   function automatic logic [7:0] obsStrobes(input int sel);
      return {nCs[sel], nAdv[sel], nWe[sel], nOe[sel], adOe[sel],
              rspValid[sel], busyO[sel], reqReady[sel]};
   endfunction

   // Reference: pin values k cycles after the accepting edge (k = 0 means idle).
   function automatic logic [7:0] expStrobes(input int k, input logic wr, input int sel);
      int  a = PA[sel];
      int  h = PH[sel];
      int  d = PD[sel];
      int  len = PA[sel] + PH[sel] + PD[sel] + PT[sel];
      bit  inAdv  = (k >= 1) && (k <= a);
      bit  inAddr = (k >= 1) && (k <= a + h);
      bit  inData = (k > a + h) && (k <= a + h + d);
      bit  inBusy = (k >= 1) && (k <= len);
      return {!(inAddr || inData), !inAdv, !(inData && wr), !(inData && !wr),
              inAddr || (inData && wr), (k == a + h + d + 1), inBusy, !inBusy};
   endfunction

   // Idle cycles with no request: nothing may move on the bus.
   task automatic idleCycles(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         reqValid = 1'b0;
         @(posedge sysClk); #1;
         checkOutput("idle_strobes", 32'(obsStrobes(sel)), 32'(expStrobes(0, 1'b0, sel)));
         checkOutput("idle_rdata", 32'(rspRdata[sel]), 32'(lastRd[sel]));
      end
   endtask

   // One transaction, started from an idle cycle; returns on the following idle cycle.
   task automatic applyStimulus(input int sel, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata);
      int capK = PA[sel] + PH[sel] + PD[sel];
      int len  = capK + PT[sel];
      checkOutput("ready_at_start", 32'(reqReady[sel]), 32'd1);
      reqValid = 1'b1;
      reqWr    = wr;
      reqAddr  = addr;
      reqWdata = wdata;
      for (int k = 1; k <= len + 1; k++) begin
         @(posedge sysClk); #1;
         // Responder: the correct word only at the last DATA cycle, junk otherwise.
         fmcAdI = (k == capK) ? rdata : (rdata ^ 16'($urandom_range(1, 65535)));
         if (k <= len) begin
            // Requests presented during a transaction must be ignored.
            reqValid = 1'($urandom_range(0, 1));
            reqWr    = 1'($urandom_range(0, 1));
            reqAddr  = 16'($urandom);
            reqWdata = 16'($urandom);
         end else begin
            reqValid = 1'b0;
         end
         checkOutput($sformatf("strobes_k%0d", k), 32'(obsStrobes(sel)), 32'(expStrobes(k, wr, sel)));
         if (k <= PA[sel] + PH[sel]) begin
            checkOutput("ad_o_addr", 32'(adO[sel]), 32'(addr));
         end else if (wr && k <= capK) begin
            checkOutput("ad_o_wdata", 32'(adO[sel]), 32'(wdata));
         end
         if (k == capK + 1) begin
            if (!wr) lastRd[sel] = rdata;
            checkOutput("rsp_err", 32'(rspErr[sel]), 32'd0);
         end
         checkOutput("rsp_rdata", 32'(rspRdata[sel]), 32'(lastRd[sel]));
      end
   endtask

   task automatic resetPulse();
      @(posedge sysClk); #3;
      rstN = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         checkOutput("reset_strobes", 32'(obsStrobes(s)), 32'(expStrobes(0, 1'b0, s)));
         checkOutput("reset_ad_o", 32'(adO[s]), 32'd0);
         checkOutput("reset_rdata", 32'(rspRdata[s]), 32'd0);
         checkOutput("reset_err", 32'(rspErr[s]), 32'd0);
         lastRd[s] = 16'd0;
      end
      #2;
      rstN = 1'b1;
      @(posedge sysClk); #1;
   endtask

   initial begin
      lastRd[0] = 16'd0;
      lastRd[1] = 16'd0;
      #2;
      resetPulse();
      idleCycles(0, 2);

      // Directed write and read.
      applyStimulus(0, 1'b1, 16'h0040, 16'hA5C3, 16'h0000);
      idleCycles(0, 1);
      applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'h1234);

      // Three writes back to back.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b1, 16'h0100 + 16'(i), 16'h5A00 + 16'(i), 16'h0000);
      end
      idleCycles(0, 2);

      // Randomized mix with random gaps (gap 0 = back to back).
      for (int i = 0; i < 30; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
         idleCycles(0, $urandom_range(0, 3));
      end

      // Reset during the DATA phase of a write.
      reqValid = 1'b1;
      reqWr    = 1'b1;
      reqAddr  = 16'h0222;
      reqWdata = 16'hBEEF;
      for (int k = 1; k <= 4; k++) begin
         @(posedge sysClk); #1;
         reqValid = 1'b0;
      end
      checkOutput("pre_abort_nwe", 32'(nWe[0]), 32'd0);
      rstN = 1'b0;
      #1;
      checkOutput("abort_strobes", 32'(obsStrobes(0)), 32'(expStrobes(0, 1'b0, 0)));
      lastRd[0] = 16'd0;
      lastRd[1] = 16'd0;
      #2;
      rstN = 1'b1;
      idleCycles(0, 10);
      applyStimulus(0, 1'b0, 16'h0333, 16'h0000, 16'hC0DE);
      applyStimulus(0, 1'b1, 16'h0444, 16'h7777, 16'h0000);

      // Minimum-timing instance.
      resetPulse();
      idleCycles(1, 1);
      applyStimulus(1, 1'b1, 16'h0ABC, 16'h1357, 16'h0000);
      applyStimulus(1, 1'b0, 16'h0DEF, 16'h0000, 16'h2468);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
         idleCycles(1, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
